// File: rtl/sha256_pkg.sv
// SHA-256 shared types, round constants, IV and the FIPS 180-4 logical functions.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t S0(input word_t a);
    return rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
  endfunction

  function automatic word_t S1(input word_t e);
    return rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_block_engine_if.sv
// Block-in / digest-out handshake bundle of the SHA-256 block engine.
interface sha256_block_engine_if;

  logic         in_valid;
  logic         in_ready;
  logic         in_chain;
  logic [255:0] h_in;
  logic [511:0] block_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] h_out;

  modport master (
    output in_valid, in_chain, h_in, block_in, out_ready,
    input  in_ready, out_valid, h_out
  );

  modport slave (
    input  in_valid, in_chain, h_in, block_in, out_ready,
    output in_ready, out_valid, h_out
  );

endinterface

// File: rtl/sha256_round.sv
// One purely combinational SHA-256 round; state packed {a,b,c,d,e,f,g,h}, a in the MSBs.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  word_t        k,
  input  word_t        w,
  output logic [255:0] state_out
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;
  assign t1 = h + S1(e) + ch(e, f, g) + k + w;
  assign t2 = S0(a) + maj(a, b, c);
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: UNROLL rounds per clock, on-chip schedule expansion, internal chaining.
// Optional debug taps state_tap/round_idx are enabled by defining SHA256_STATE_TAP_EN.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_block_engine_if.slave bus,
  output logic                 busy
`ifdef SHA256_STATE_TAP_EN
  ,
  output logic [255:0]         state_tap,
  output logic [6:0]           round_idx
`endif
);

  localparam int NROUND_CYC = 64 / UNROLL;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_block_engine: UNROLL must be 1, 2, 4 or 8, got %0d", UNROLL);
  end

  state_t       state;
  logic [5:0]   cnt;
  word_t        win [16];
  logic [255:0] work;
  logic [255:0] saved_h;
  logic [255:0] digest;
  logic [255:0] h_out_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;

  word_t        ext [16+UNROLL];
  logic [5:0]   t_base;
  logic [255:0] final_sum;
  logic [255:0] chain_val;

  assign t_base    = 6'(cnt * UNROLL);
  assign chain_val = bus.in_chain ? digest : bus.h_in;

  // ext[0..UNROLL-1] feed this cycle's rounds; ext[UNROLL..UNROLL+15] is next cycle's window.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = sig1(ext[14+j]) + ext[9+j] + sig0(ext[1+j]) + ext[j];
  end

  for (genvar r = 0; r < UNROLL; r++) begin : g_round
    logic [255:0] st_out;
    if (r == 0) begin : g_first
      sha256_round u_round (
        .state_in  (work),
        .k         (K[6'(t_base + r)]),
        .w         (ext[r]),
        .state_out (st_out)
      );
    end else begin : g_next
      sha256_round u_round (
        .state_in  (g_round[r-1].st_out),
        .k         (K[6'(t_base + r)]),
        .w         (ext[r]),
        .state_out (st_out)
      );
    end
  end

  always_comb begin
    final_sum = '0;
    for (int i = 0; i < 8; i++)
      final_sum[32*i +: 32] = saved_h[32*i +: 32] + work[32*i +: 32];
  end

  // Reset returns the digest register to the IV, so any partial chain is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      saved_h     <= '0;
      digest      <= IV;
      h_out_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            for (int i = 0; i < 16; i++) win[i] <= bus.block_in[511-32*i -: 32];
            work       <= chain_val;
            saved_h    <= chain_val;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= ROUND;
          end
        end
        ROUND: begin
          work <= g_round[UNROLL-1].st_out;
          for (int i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
          cnt <= cnt + 6'd1;
          if (cnt == 6'(NROUND_CYC - 1)) state <= FINAL;
        end
        FINAL: begin
          digest      <= final_sum;
          h_out_r     <= final_sum;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.h_out     = h_out_r;
  assign busy          = busy_r;

`ifdef SHA256_STATE_TAP_EN
  assign state_tap = busy_r ? work : '0;
  assign round_idx = 7'(cnt * UNROLL);
`endif

endmodule

// File: tb/tb_sha256_block_engine.sv
// Testbench for sha256_block_engine: cycle-level reference model plus directed FIPS 180-4 vectors.
module tb_sha256_block_engine;

  parameter int UNROLL = 4;
  localparam int NROUND_CYC = 64 / UNROLL;
  localparam int LIMIT = 300;

  localparam logic [255:0] TB_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
  localparam logic [511:0] TWO1_BLK  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO2_BLK  = {480'd0, 32'h000001c0};

  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic clk;
  logic reset;
  logic busy;
  int   checks;
  int   errors;
  logic cmp_en;

`ifdef SHA256_STATE_TAP_EN
  logic [255:0] state_tap;
  logic [6:0]   round_idx;
`endif

  sha256_block_engine_if bus ();

  sha256_block_engine #(.UNROLL(UNROLL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
`ifdef SHA256_STATE_TAP_EN
    ,
    .state_tap (state_tap),
    .round_idx (round_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight textbook compression: 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] sha256_compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: accept, fixed latency to digest, hold until out_ready.
  int           m_cyc;
  logic         m_in_ready;
  logic         m_out_valid;
  logic         m_busy;
  logic [255:0] m_h_out;
  logic [255:0] m_chain;
  logic [255:0] m_pending;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc       = -1;
      m_in_ready  = 1'b1;
      m_out_valid = 1'b0;
      m_busy      = 1'b0;
      m_h_out     = '0;
      m_chain     = TB_IV;
    end else if (m_in_ready) begin
      if (bus.in_valid) begin
        m_pending  = sha256_compress(bus.in_chain ? m_chain : bus.h_in, bus.block_in);
        m_cyc      = 0;
        m_in_ready = 1'b0;
        m_busy     = 1'b1;
      end
    end else if (!m_out_valid) begin
      m_cyc++;
      if (m_cyc == NROUND_CYC + 1) begin
        m_out_valid = 1'b1;
        m_h_out     = m_pending;
        m_chain     = m_pending;
      end
    end else if (bus.out_ready) begin
      m_out_valid = 1'b0;
      m_in_ready  = 1'b1;
      m_busy      = 1'b0;
      m_cyc       = -1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cyc_out_valid", 256'(bus.out_valid), 256'(m_out_valid));
      check_output("cyc_in_ready", 256'(bus.in_ready), 256'(m_in_ready));
      check_output("cyc_busy", 256'(busy), 256'(m_busy));
      check_output("cyc_h_out", bus.h_out, m_h_out);
    end
  end

  // Present one block, scramble the inputs after accept, wait for the digest, optionally stall, release.
  task automatic apply_stimulus(input logic chain, input logic [255:0] hv, input logic [511:0] blk,
                                input int stall, output logic [255:0] dig, output int lat);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("accept_wait", 256'(n < LIMIT), 256'd1);
    bus.in_chain = chain;
    bus.h_in     = hv;
    bus.block_in = blk;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_chain = ~chain;
    bus.h_in     = ~hv;
    bus.block_in = ~blk;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check_output("latency", 256'(lat), 256'(NROUND_CYC + 1));
    dig = bus.h_out;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.in_chain = 1'b0;
      bus.block_in = {16{32'hdeadbeef}};
      @(posedge clk); #1;
      check_output("hold_out_valid", 256'(bus.out_valid), 256'd1);
      check_output("hold_h_out", bus.h_out, dig);
      check_output("hold_in_ready", 256'(bus.in_ready), 256'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_output("release_out_valid", 256'(bus.out_valid), 256'd0);
    check_output("release_in_ready", 256'(bus.in_ready), 256'd1);
  endtask

  initial begin
    logic [255:0] dig;
    int           lat;
    checks        = 0;
    errors        = 0;
    cmp_en        = 1'b0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_chain  = 1'b0;
    bus.h_in      = '0;
    bus.block_in  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_out_valid", 256'(bus.out_valid), 256'd0);
    check_output("rst_in_ready", 256'(bus.in_ready), 256'd1);
    check_output("rst_busy", 256'(busy), 256'd0);
    check_output("rst_h_out", bus.h_out, 256'd0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    check_output("model_abc", sha256_compress(TB_IV, ABC_BLK), ABC_DIG);
    check_output("model_empty", sha256_compress(TB_IV, EMPTY_BLK), EMPTY_DIG);
    check_output("model_two", sha256_compress(sha256_compress(TB_IV, TWO1_BLK), TWO2_BLK), TWO_DIG);

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_output("stray_ready_out_valid", 256'(bus.out_valid), 256'd0);
    check_output("stray_ready_in_ready", 256'(bus.in_ready), 256'd1);

    apply_stimulus(1'b1, 256'h0123456789abcdef_0123456789abcdef_0123456789abcdef_0123456789abcdef,
                   ABC_BLK, 0, dig, lat);
    check_output("abc_digest", dig, ABC_DIG);

    apply_stimulus(1'b0, TB_IV, EMPTY_BLK, 10, dig, lat);
    check_output("empty_digest", dig, EMPTY_DIG);

    apply_stimulus(1'b0, TB_IV, TWO1_BLK, 0, dig, lat);
    apply_stimulus(1'b1, {8{32'hffff0000}}, TWO2_BLK, 0, dig, lat);
    check_output("two_block_digest", dig, TWO_DIG);

    bus.in_chain = 1'b0;
    bus.h_in     = TB_IV;
    bus.block_in = TWO1_BLK;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (NROUND_CYC / 2) @(posedge clk);
    #1;
    check_output("pre_abort_busy", 256'(busy), 256'd1);
    reset = 1'b0;
    #1;
    check_output("abort_out_valid", 256'(bus.out_valid), 256'd0);
    check_output("abort_in_ready", 256'(bus.in_ready), 256'd1);
    check_output("abort_busy", 256'(busy), 256'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    apply_stimulus(1'b1, {8{32'h5a5a5a5a}}, ABC_BLK, 0, dig, lat);
    check_output("abc_after_abort", dig, ABC_DIG);

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
